// File: rtl/acc_ctrl_pkg.sv
// Shared types and constants for the round-robin accumulator controller.
// The hold constants describe the accumulator input that leaves its sum unchanged.
package acc_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_CLR  = 2'b10,
    OP_READ = 2'b11
  } acc_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    CAPTURE = 2'b10,
    RESP    = 2'b11
  } ctrl_state_e;

  localparam logic        HOLD_ADD_SUB = 1'b0;
  localparam logic [31:0] HOLD_A       = 32'd0;

  // Round-robin successor of a requester index, wrapping at n.
  function automatic int next_ptr(input int idx, input int n);
    return (idx == n - 32'sd1) ? 32'sd0 : idx + 32'sd1;
  endfunction

endpackage

// File: rtl/acc_rr_controller_if.sv
// Requester command and response bundle of the accumulator controller.
// The slave modport is the controller side, the master modport the requester/consumer side.
interface acc_rr_controller_if #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 8,
  parameter int ID_W    = (NUM_REQ > 32'sd1) ? $clog2(NUM_REQ) : 32'sd1
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [2*NUM_REQ-1:0]     req_op;
  logic [WIDTH*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_carry;
  logic                     rsp_ovf;

  modport master (
    output req_valid, req_op, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_ovf
  );

  modport slave (
    input  req_valid, req_op, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_ovf
  );

endinterface

// File: rtl/acc_rr_controller_rr_arbiter.sv
// Round-robin picker: first valid requester at or after ptr, wrapping around.
// Purely combinational; the caller owns and advances the pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx,
  output logic               grant_any
);

  logic hit_s;

  // Two passes: indices from ptr upward first, then the wrapped ones below ptr.
  always_comb begin
    grant     = {NUM_REQ{1'b0}};
    grant_idx = {ID_W{1'b0}};
    grant_any = 1'b0;
    hit_s     = 1'b0;
    for (int j = 32'sd0; j < NUM_REQ; j++) begin
      hit_s     = valid[j] & ~grant_any & (j >= int'(ptr));
      grant[j]  = hit_s;
      grant_idx = hit_s ? ID_W'(j) : grant_idx;
      grant_any = grant_any | hit_s;
    end
    for (int j = 32'sd0; j < NUM_REQ; j++) begin
      hit_s     = valid[j] & ~grant_any & (j < int'(ptr));
      grant[j]  = grant[j] | hit_s;
      grant_idx = hit_s ? ID_W'(j) : grant_idx;
      grant_any = grant_any | hit_s;
    end
  end

endmodule

// File: rtl/acc_rr_controller.sv
// Shares one registered add/subtract accumulator among NUM_REQ requesters:
// one accumulator update per accepted command, result returned tagged with the requester id.
module acc_rr_controller
  import acc_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 8,
  parameter int ID_W    = (NUM_REQ > 32'sd1) ? $clog2(NUM_REQ) : 32'sd1
) (
  input  logic               i_clk,
  input  logic               ni_rst,
  acc_rr_controller_if.slave bus,
  output logic               o_ovf_sticky,
  output logic               o_acc_add_sub,
  output logic [WIDTH-1:0]   o_acc_a,
  input  logic [WIDTH-1:0]   i_acc_sum,
  input  logic               i_acc_carry,
  input  logic               i_acc_ovf
);

  ctrl_state_e        state_r, state_nxt_s;
  logic [ID_W-1:0]    ptr_r, ptr_nxt_s;
  logic [ID_W-1:0]    id_r;
  acc_op_e            op_r;
  logic               load_s;

  logic [NUM_REQ-1:0] grant_s;
  logic [ID_W-1:0]    grant_idx_s;
  logic               grant_any_s;
  acc_op_e            grant_op_s;
  logic [WIDTH-1:0]   grant_data_s;
  logic [NUM_REQ-1:0] req_ready_s;

  logic [WIDTH-1:0]   acc_a_r, acc_a_nxt_s;
  logic               acc_add_sub_r, acc_add_sub_nxt_s;

  logic               rsp_valid_r;
  logic [ID_W-1:0]    rsp_id_r;
  logic [WIDTH-1:0]   rsp_data_r;
  logic               rsp_carry_r;
  logic               rsp_ovf_r;
  logic               ovf_sticky_r;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .valid     (bus.req_valid),
    .ptr       (ptr_r),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .grant_any (grant_any_s)
  );

  // Select the granted requester's op and operand.
  always_comb begin
    grant_op_s   = OP_ADD;
    grant_data_s = {WIDTH{1'b0}};
    for (int j = 32'sd0; j < NUM_REQ; j++) begin
      grant_op_s   = (int'(grant_idx_s) == j) ? acc_op_e'(bus.req_op[32'sd2*j +: 2]) : grant_op_s;
      grant_data_s = (int'(grant_idx_s) == j) ? bus.req_data[j*WIDTH +: WIDTH] : grant_data_s;
    end
  end

  // Sequencing FSM; the accumulator drive for ISSUE is prepared in IDLE and registered.
  always_comb begin
    state_nxt_s       = state_r;
    ptr_nxt_s         = ptr_r;
    load_s            = 1'b0;
    req_ready_s       = {NUM_REQ{1'b0}};
    acc_a_nxt_s       = WIDTH'(HOLD_A);
    acc_add_sub_nxt_s = HOLD_ADD_SUB;
    case (state_r)
      IDLE: begin
        if (grant_any_s) begin
          state_nxt_s = ISSUE;
          ptr_nxt_s   = ID_W'(next_ptr(int'(grant_idx_s), NUM_REQ));
          load_s      = 1'b1;
          req_ready_s = grant_s;
          case (grant_op_s)
            OP_ADD: begin
              acc_a_nxt_s       = grant_data_s;
              acc_add_sub_nxt_s = 1'b0;
            end
            OP_SUB: begin
              acc_a_nxt_s       = grant_data_s;
              acc_add_sub_nxt_s = 1'b1;
            end
            // Sum is held through IDLE, so S - S clears it with carry=1, ovf=0.
            OP_CLR: begin
              acc_a_nxt_s       = i_acc_sum;
              acc_add_sub_nxt_s = 1'b1;
            end
            OP_READ: begin
              acc_a_nxt_s       = WIDTH'(HOLD_A);
              acc_add_sub_nxt_s = HOLD_ADD_SUB;
            end
            default: begin
              acc_a_nxt_s       = WIDTH'(HOLD_A);
              acc_add_sub_nxt_s = HOLD_ADD_SUB;
            end
          endcase
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE:   state_nxt_s = CAPTURE;
      CAPTURE: state_nxt_s = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, round-robin pointer and latched command attributes.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      state_r <= IDLE;
      ptr_r   <= {ID_W{1'b0}};
      op_r    <= OP_ADD;
      id_r    <= {ID_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      if (load_s) begin
        op_r <= grant_op_s;
        id_r <= grant_idx_s;
      end else begin
        op_r <= op_r;
        id_r <= id_r;
      end
    end
  end

  // Accumulator drive: non-hold for exactly the ISSUE cycle.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      acc_a_r       <= {WIDTH{1'b0}};
      acc_add_sub_r <= 1'b0;
    end else begin
      acc_a_r       <= acc_a_nxt_s;
      acc_add_sub_r <= acc_add_sub_nxt_s;
    end
  end

  // Response capture in CAPTURE; fields stay frozen while RESP is backpressured.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= {ID_W{1'b0}};
      rsp_data_r   <= {WIDTH{1'b0}};
      rsp_carry_r  <= 1'b0;
      rsp_ovf_r    <= 1'b0;
      ovf_sticky_r <= 1'b0;
    end else if (state_r == CAPTURE) begin
      rsp_valid_r  <= 1'b1;
      rsp_id_r     <= id_r;
      rsp_data_r   <= i_acc_sum;
      rsp_carry_r  <= i_acc_carry;
      rsp_ovf_r    <= i_acc_ovf;
      ovf_sticky_r <= (op_r == OP_CLR) ? 1'b0 : (ovf_sticky_r | i_acc_ovf);
    end else if ((state_r == RESP) && bus.rsp_ready) begin
      rsp_valid_r  <= 1'b0;
    end else begin
      rsp_valid_r  <= rsp_valid_r;
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.rsp_valid  = rsp_valid_r;
  assign bus.rsp_id     = rsp_id_r;
  assign bus.rsp_data   = rsp_data_r;
  assign bus.rsp_carry  = rsp_carry_r;
  assign bus.rsp_ovf    = rsp_ovf_r;
  assign o_ovf_sticky   = ovf_sticky_r;
  assign o_acc_a        = acc_a_r;
  assign o_acc_add_sub  = acc_add_sub_r;

endmodule

// File: tb/tb_acc_rr_controller.sv
// Bench for acc_rr_controller with a registered 8-bit accumulator attached, an
// arithmetic reference model of the whole command/response behaviour, and pinned literals.
module tb_acc_rr_controller;
  import acc_ctrl_pkg::*;

  localparam int N = 2;
  localparam int W = 8;

  typedef struct { int id; int data; int c; int o; int st; int due; } rsp_t;
  typedef struct { int id; int data; int c; int o; int st; } pin_t;

  logic       clk;
  logic       rst_n;
  logic       acc_add_sub;
  logic [7:0] acc_a;
  logic [7:0] acc_sum;
  logic       acc_carry;
  logic       acc_ovf;
  logic       ovf_sticky;
  logic       drv_valid [N];
  logic [1:0] drv_op    [N];
  logic [7:0] drv_data  [N];
  logic       rsp_rdy;

  acc_rr_controller_if #(.NUM_REQ(N), .WIDTH(W), .ID_W(1)) bus ();

  assign bus.req_valid = {drv_valid[1], drv_valid[0]};
  assign bus.req_op    = {drv_op[1], drv_op[0]};
  assign bus.req_data  = {drv_data[1], drv_data[0]};
  assign bus.rsp_ready = rsp_rdy;

  acc_rr_controller #(.NUM_REQ(N), .WIDTH(W), .ID_W(1)) dut (
    .i_clk         (clk),
    .ni_rst        (rst_n),
    .bus           (bus.slave),
    .o_ovf_sticky  (ovf_sticky),
    .o_acc_add_sub (acc_add_sub),
    .o_acc_a       (acc_a),
    .i_acc_sum     (acc_sum),
    .i_acc_carry   (acc_carry),
    .i_acc_ovf     (acc_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Accumulator: S <= S + A or S + ~A + 1, registered carry and signed overflow.
  logic [8:0] acc_full_s;
  logic [7:0] acc_b_s;
  always_comb begin
    acc_b_s    = acc_add_sub ? ~acc_a : acc_a;
    acc_full_s = {1'b0, acc_sum} + {1'b0, acc_b_s} + {8'd0, acc_add_sub};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_sum   <= 8'd0;
      acc_carry <= 1'b0;
      acc_ovf   <= 1'b0;
    end else begin
      acc_sum   <= acc_full_s[7:0];
      acc_carry <= acc_full_s[8];
      acc_ovf   <= (acc_sum[7] == acc_b_s[7]) && (acc_full_s[7] != acc_sum[7]);
    end
  end

  // Written only by the stimulus process.
  pin_t pins [32];
  int   pin_wr;
  int   tmo_cnt;
  bit   done;

  // Written only by the compare process.
  int   cyc, n_chk, n_fail, pin_rd;
  int   m_sum, m_sticky, m_sticky_vis, m_ptr;
  bit   m_free, m_pend;
  int   issue_cyc, issue_a, issue_sub, apply_cyc, apply_sum;
  rsp_t m_q [$];
  rsp_t m_cur;
  int   exp_g, g, op, d, s, res, c, o, a, sub, st, sres;

  function automatic int sx(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: cycle %0d got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Reference model and compare process, evaluated on every falling edge.
  initial begin
    cyc = 0; n_chk = 0; n_fail = 0; pin_rd = 0;
    m_sum = 0; m_sticky = 0; m_sticky_vis = 0; m_ptr = 0; m_free = 1'b1; m_pend = 1'b0;
    issue_cyc = -1; issue_a = 0; issue_sub = 0; apply_cyc = -1; apply_sum = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done) begin
        chk("wait_timeouts", tmo_cnt, 0);
        chk("pinned_rsps_seen", pin_rd, pin_wr);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
      end
      if (!rst_n) begin
        chk("rst_req_ready", int'(bus.req_ready), 0);
        chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
        chk("rst_rsp_id", int'(bus.rsp_id), 0);
        chk("rst_rsp_data", int'(bus.rsp_data), 0);
        chk("rst_rsp_flags", int'({bus.rsp_carry, bus.rsp_ovf}), 0);
        chk("rst_sticky", int'(ovf_sticky), 0);
        chk("rst_acc_drive", int'({acc_add_sub, acc_a}), 0);
        chk("rst_acc_sum", int'(acc_sum), 0);
        m_sum = 0; m_sticky = 0; m_sticky_vis = 0; m_ptr = 0; m_free = 1'b1; m_pend = 1'b0;
        issue_cyc = -1; apply_cyc = -1;
        m_q.delete();
      end else begin
        if (cyc == apply_cyc) m_sum = apply_sum;
        chk("acc_sum", int'(acc_sum), m_sum);
        chk("acc_a", int'(acc_a), (cyc == issue_cyc) ? issue_a : 0);
        chk("acc_add_sub", int'(acc_add_sub), (cyc == issue_cyc) ? issue_sub : 0);

        exp_g = -1;
        if (m_free) begin
          for (int k = 0; k < N; k++) begin
            g = (m_ptr + k) % N;
            if (exp_g < 0 && ((int'(bus.req_valid) >> g) & 1) == 1) exp_g = g;
          end
        end
        chk("req_ready", int'(bus.req_ready), (exp_g < 0) ? 0 : (1 << exp_g));
        if (exp_g >= 0) begin
          op = (int'(bus.req_op) >> (2 * exp_g)) & 3;
          d  = (int'(bus.req_data) >> (8 * exp_g)) & 255;
          s  = m_sum;
          case (op)
            0: begin
              res = (s + d) % 256; c = (s + d > 255) ? 1 : 0;
              sres = sx(s) + sx(d); o = (sres > 127 || sres < -128) ? 1 : 0;
              a = d; sub = 1'b0;
            end
            1: begin
              res = (s - d + 256) % 256; c = (s >= d) ? 1 : 0;
              sres = sx(s) - sx(d); o = (sres > 127 || sres < -128) ? 1 : 0;
              a = d; sub = 1;
            end
            2: begin
              res = 0; c = 1; o = 0; a = s; sub = 1;
            end
            default: begin
              res = s; c = 0; o = 0; a = 0; sub = 0;
            end
          endcase
          st = (op == 2) ? 0 : (m_sticky | o);
          m_sticky = st;
          m_q.push_back('{exp_g, res, c, o, st, cyc + 3});
          issue_cyc = cyc + 1; issue_a = a; issue_sub = sub;
          apply_cyc = cyc + 2; apply_sum = res;
          m_ptr = (exp_g + 1) % N;
          m_free = 1'b0;
        end

        if (!m_pend && m_q.size() > 0 && m_q[0].due == cyc) begin
          m_cur = m_q.pop_front();
          m_pend = 1'b1;
          m_sticky_vis = m_cur.st;
          if (pin_rd < pin_wr) begin
            chk("pin_id", int'(bus.rsp_id), pins[pin_rd].id);
            chk("pin_data", int'(bus.rsp_data), pins[pin_rd].data);
            chk("pin_carry", int'(bus.rsp_carry), pins[pin_rd].c);
            chk("pin_ovf", int'(bus.rsp_ovf), pins[pin_rd].o);
            chk("pin_sticky", int'(ovf_sticky), pins[pin_rd].st);
            pin_rd++;
          end else begin
            chk("rsp_pin_available", pin_wr - pin_rd, 1);
          end
        end
        chk("rsp_valid", int'(bus.rsp_valid), int'(m_pend));
        if (m_pend) begin
          chk("rsp_id", int'(bus.rsp_id), m_cur.id);
          chk("rsp_data", int'(bus.rsp_data), m_cur.data);
          chk("rsp_carry", int'(bus.rsp_carry), m_cur.c);
          chk("rsp_ovf", int'(bus.rsp_ovf), m_cur.o);
          if (bus.rsp_ready) begin
            m_pend = 1'b0;
            m_free = 1'b1;
          end
        end
        chk("ovf_sticky", int'(ovf_sticky), m_sticky_vis);
      end
    end
  end

  task automatic pin(input int id, input int data, input int c, input int o, input int st);
    pins[pin_wr] = '{id, data, c, o, st};
    pin_wr++;
  endtask

  task automatic start_req(input int r, input logic [1:0] op_i, input logic [7:0] d_i);
    drv_valid[r] = 1'b1;
    drv_op[r]    = op_i;
    drv_data[r]  = d_i;
  endtask

  task automatic wait_accept(input int r);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      got = ((int'(bus.req_ready) >> r) & 1) == 1;
    end
    if (!got) tmo_cnt++;
    @(posedge clk);
    #1;
    drv_valid[r] = 1'b0;
  endtask

  task automatic wait_rsp();
    bit got;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      got = bus.rsp_valid && bus.rsp_ready;
    end
    if (!got) tmo_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input int r, input logic [1:0] op_i, input logic [7:0] d_i,
                     input int id, input int data, input int c, input int o, input int st);
    pin(id, data, c, o, st);
    start_req(r, op_i, d_i);
    wait_accept(r);
    wait_rsp();
  endtask

  // Directed stimulus.
  initial begin
    int  cnt0, cnt1;
    logic [N-1:0] rdy;
    rst_n = 1'b0; rsp_rdy = 1'b1; done = 1'b0; tmo_cnt = 0; pin_wr = 0;
    for (int r = 0; r < N; r++) begin
      drv_valid[r] = 1'b0; drv_op[r] = 2'b00; drv_data[r] = 8'd0;
    end
    #22 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    cmd(0, OP_ADD,  8'd5,   0, 5,   0, 0, 0);
    cmd(0, OP_ADD,  8'd10,  0, 15,  0, 0, 0);
    cmd(0, OP_SUB,  8'd30,  0, 241, 0, 0, 0);
    cmd(0, OP_CLR,  8'd0,   0, 0,   1, 0, 0);
    cmd(0, OP_ADD,  8'd70,  0, 70,  0, 0, 0);
    cmd(0, OP_ADD,  8'd70,  0, 140, 0, 1, 1);
    cmd(0, OP_SUB,  8'd1,   0, 139, 1, 0, 1);
    cmd(0, OP_READ, 8'd0,   0, 139, 0, 0, 1);
    cmd(1, OP_CLR,  8'd0,   1, 0,   1, 0, 0);

    // Both requesters hold ADD 1 continuously: grants must alternate 0,1,0,1.
    pin(0, 1, 0, 0, 0); pin(1, 2, 0, 0, 0); pin(0, 3, 0, 0, 0); pin(1, 4, 0, 0, 0);
    start_req(0, OP_ADD, 8'd1);
    start_req(1, OP_ADD, 8'd1);
    cnt0 = 0; cnt1 = 0;
    for (int k = 0; k < 200 && (cnt0 < 2 || cnt1 < 2); k++) begin
      @(negedge clk);
      rdy = bus.req_ready;
      @(posedge clk);
      #1;
      if (rdy[0]) begin cnt0++; if (cnt0 == 2) drv_valid[0] = 1'b0; end
      if (rdy[1]) begin cnt1++; if (cnt1 == 2) drv_valid[1] = 1'b0; end
    end
    if (cnt0 < 2 || cnt1 < 2) tmo_cnt++;
    wait_rsp();

    // Response backpressure with a competing request pending.
    rsp_rdy = 1'b0;
    pin(0, 11, 0, 0, 0);
    start_req(0, OP_ADD, 8'd7);
    wait_accept(0);
    pin(1, 13, 0, 0, 0);
    start_req(1, OP_ADD, 8'd2);
    repeat (8) @(posedge clk);
    #1;
    rsp_rdy = 1'b1;
    wait_rsp();
    wait_accept(1);
    wait_rsp();

    // Reset during ISSUE: command dropped, everything back to zero.
    start_req(0, OP_ADD, 8'd9);
    wait_accept(0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    cmd(1, OP_ADD, 8'h7F, 1, 127, 0, 0, 0);
    cmd(0, OP_ADD, 8'd1,  0, 128, 0, 1, 1);
    cmd(1, OP_ADD, 8'h80, 1, 0,   1, 1, 1);

    repeat (3) @(posedge clk);
    #1;
    done = 1'b1;
  end

endmodule
